// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard controller.
//   - RA_W            : default register-address width
//   - state_e         : controller FSM states (RUN / MEM_WAIT / ERR)
//   - FWD_REG/MEM/WB  : ALU operand forwarding-select encodings
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // operand from MEM-stage result
    localparam logic [1:0] FWD_WB  = 2'b10;  // operand from WB-stage result

endpackage

// File: rtl/hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
//   Combinational compare of one source register against one downstream
//   destination register. x0 is hardwired to zero, so it never matches.
// Ports:
//   rs_i        source register address (instruction in ID)
//   rs_used_i   ID instruction actually reads rs_i
//   rd_i        destination register address of a downstream stage
//   rd_write_i  downstream instruction writes rd_i
//   hit_o       1 when the source depends on that destination
// ---------------------------------------------------------------------------
module hazard_match #(
    parameter int RA_W = pipe_ctrl_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic            rs_used_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic            rd_write_i,
    output logic            hit_o
);

    assign hit_o = rs_used_i & rd_write_i & (rd_i != '0) & (rs_i == rd_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Sequences a 5-stage IF/ID/EX/MEM/WB pipeline: generates the pipeline
//   register write enables, IF/ID flush, ID/EX bubble and ALU forwarding
//   selects. Handles load-use / RAW stalls, taken-branch flushes and
//   multi-cycle data-memory waits with a timeout into a sticky error state.
//
// Configuration macro:
//   FWD_UNIT_EN  defined   : forwarding unit present, only load-use stalls
//                undefined : no forwarding, stall on EX or MEM writer match
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs1/id_rs2            source registers of the ID instruction
//   id_use_rs1/id_use_rs2    ID instruction reads rs1/rs2
//   ex_rd/ex_reg_write       EX destination and write flag
//   ex_mem_read              EX instruction is a load
//   mem_rd/mem_reg_write     MEM destination and write flag
//   wb_rd/wb_reg_write       WB destination and write flag
//   branch_taken             EX resolved a taken branch
//   dmem_req/dmem_ack        data-memory access / completion in MEM
//   pc_write .. exmem_write  pipeline register control
//   fwd_a/fwd_b              ALU operand selects (00 reg, 01 MEM, 10 WB)
//   mem_tmo_err              sticky data-memory timeout error
//   stall_cnt                saturating count of cycles with pc_write=0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int RA_W    = pipe_ctrl_pkg::RA_W,
    parameter int MEM_TMO = 15,
    parameter int TMO_W   = 4,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic              mem_reg_write,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic              wb_reg_write,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_write,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_tmo_err,
    output logic [PERF_W-1:0] stall_cnt
);

    import pipe_ctrl_pkg::*;

    // -----------------------------------------------------------------------
    // Dependency matrix: hit[r][s] = ID source r depends on stage s writer
    //   r: 0 = rs1, 1 = rs2      s: 0 = EX, 1 = MEM, 2 = WB
    // -----------------------------------------------------------------------
    logic [RA_W-1:0] src_rs   [2];
    logic [1:0]      src_used;
    logic [RA_W-1:0] stage_rd [3];
    logic [2:0]      stage_we;
    logic [2:0]      hit      [2];

    assign src_rs[0]   = id_rs1;
    assign src_rs[1]   = id_rs2;
    assign src_used    = {id_use_rs2, id_use_rs1};
    assign stage_rd[0] = ex_rd;
    assign stage_rd[1] = mem_rd;
    assign stage_rd[2] = wb_rd;
    assign stage_we    = {wb_reg_write, mem_reg_write, ex_reg_write};

    genvar gr, gi;
    generate
        for (gr = 0; gr < 2; gr++) begin : g_src
            for (gi = 0; gi < 3; gi++) begin : g_stage
                hazard_match #(.RA_W(RA_W)) u_match (
                    .rs_i       (src_rs[gr]),
                    .rs_used_i  (src_used[gr]),
                    .rd_i       (stage_rd[gi]),
                    .rd_write_i (stage_we[gi]),
                    .hit_o      (hit[gr][gi])
                );
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // RAW stall condition and forwarding selects
    // -----------------------------------------------------------------------
    logic       raw_stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

`ifdef FWD_UNIT_EN
    // With forwarding only a load in EX cannot be bypassed in time.
    assign raw_stall = ex_mem_read & (hit[0][0] | hit[1][0]);
    // MEM holds the younger write to the same register, so it wins over WB.
    assign fwd_a_sel = hit[0][1] ? FWD_MEM : (hit[0][2] ? FWD_WB : FWD_REG);
    assign fwd_b_sel = hit[1][1] ? FWD_MEM : (hit[1][2] ? FWD_WB : FWD_REG);
`else
    // No bypass: wait until the producer reaches WB; the write-first
    // register file covers the WB case.
    assign raw_stall = hit[0][0] | hit[0][1] | hit[1][0] | hit[1][1];
    assign fwd_a_sel = FWD_REG;
    assign fwd_b_sel = FWD_REG;
    logic unused_nofwd;
    assign unused_nofwd = &{1'b0, ex_mem_read, hit[0][2], hit[1][2]};
`endif

    // -----------------------------------------------------------------------
    // FSM and timeout counter
    // -----------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [TMO_W-1:0]  tmo_inc;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              freeze;

    logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w;

    assign tmo_inc = tmo_q + TMO_W'(1);
    assign freeze  = ((state_q == ST_RUN) & dmem_req & ~dmem_ack) |
                     ((state_q == ST_MEM_WAIT) & ~dmem_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            tmo_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        ifid_f  = 1'b0;
        idex_w  = 1'b1;
        idex_b  = 1'b0;
        exmem_w = 1'b1;

        if (state_q == ST_ERR) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
        end else if (freeze) begin
            // Whole pipeline holds; EX keeps any taken branch for release.
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            tmo_d   = tmo_inc;
            state_d = (tmo_inc == TMO_W'(MEM_TMO)) ? ST_ERR : ST_MEM_WAIT;
        end else begin
            // RUN, or MEM_WAIT on the ack (release) cycle.
            state_d = ST_RUN;
            tmo_d   = '0;
            if (branch_taken) begin
                // Squash the two wrong-path instructions; redirect PC.
                ifid_f = 1'b1;
                idex_b = 1'b1;
            end else if (raw_stall) begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                idex_b = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: reset forces a safe pipeline state (flush + bubble, no writes)
    // -----------------------------------------------------------------------
    assign pc_write    = rst ? 1'b0    : pc_w;
    assign ifid_write  = rst ? 1'b0    : ifid_w;
    assign ifid_flush  = rst ? 1'b1    : ifid_f;
    assign idex_write  = rst ? 1'b1    : idex_w;
    assign idex_bubble = rst ? 1'b1    : idex_b;
    assign exmem_write = rst ? 1'b0    : exmem_w;
    assign fwd_a       = rst ? FWD_REG : fwd_a_sel;
    assign fwd_b       = rst ? FWD_REG : fwd_b_sel;
    assign mem_tmo_err = ~rst & (state_q == ST_ERR);
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int RA_W    = 5;
    localparam int MEM_TMO = 15;
    localparam int PERF_W  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
    logic            mem_reg_write, wb_reg_write, branch_taken, dmem_req, dmem_ack;
    logic            pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
    logic [1:0]      fwd_a, fwd_b;
    logic            mem_tmo_err;
    logic [PERF_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: length of the current unacknowledged memory
    // wait, sticky error flag and stall counter.
    int m_wait  = 0;
    bit m_err   = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .RA_W(RA_W), .MEM_TMO(MEM_TMO), .TMO_W(4), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_tmo_err(mem_tmo_err), .stall_cnt(stall_cnt)
    );

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, fwd_a, fwd_b, mem_tmo_err}
    function automatic logic [10:0] observed();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                exmem_write, fwd_a, fwd_b, mem_tmo_err};
    endfunction

    function automatic bit dep(input logic [RA_W-1:0] rs, input logic used,
                               input logic [RA_W-1:0] rd, input logic wr);
        return used && wr && (rd != 0) && (rs == rd);
    endfunction

    // Expected outputs from the current inputs and model state.
    function automatic logic [10:0] model_out();
        bit freeze, raw, d1ex, d2ex, d1mem, d2mem, d1wb, d2wb;
        logic [1:0] fa, fb;
        d1ex  = dep(id_rs1, id_use_rs1, ex_rd,  ex_reg_write);
        d2ex  = dep(id_rs2, id_use_rs2, ex_rd,  ex_reg_write);
        d1mem = dep(id_rs1, id_use_rs1, mem_rd, mem_reg_write);
        d2mem = dep(id_rs2, id_use_rs2, mem_rd, mem_reg_write);
        d1wb  = dep(id_rs1, id_use_rs1, wb_rd,  wb_reg_write);
        d2wb  = dep(id_rs2, id_use_rs2, wb_rd,  wb_reg_write);
`ifdef FWD_UNIT_EN
        raw = ex_mem_read && (d1ex || d2ex);
        fa  = d1mem ? 2'b01 : (d1wb ? 2'b10 : 2'b00);
        fb  = d2mem ? 2'b01 : (d2wb ? 2'b10 : 2'b00);
`else
        raw = d1ex || d2ex || d1mem || d2mem;
        fa  = 2'b00;
        fb  = 2'b00;
        if (d1wb || d2wb) fa = 2'b00;  // WB covered by the register file
`endif
        freeze = !dmem_ack && (dmem_req || (m_wait > 0));
        if (m_err)             return {6'b000000, fa, fb, 1'b1};
        else if (freeze)       return {6'b000000, fa, fb, 1'b0};
        else if (branch_taken) return {6'b111111, fa, fb, 1'b0};
        else if (raw)          return {6'b000111, fa, fb, 1'b0};
        else                   return {6'b110101, fa, fb, 1'b0};
    endfunction

    // Clock edge: advance the model with the inputs that were applied.
    task automatic advance();
        logic [10:0] e;
        bit freeze;
        e = model_out();
        freeze = !dmem_ack && (dmem_req || (m_wait > 0));
        @(posedge clk);
        if (e[10] == 1'b0 && m_stall < (1 << PERF_W) - 1) m_stall++;
        if (!m_err) begin
            if (freeze) begin
                m_wait++;
                if (m_wait == MEM_TMO) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
        branch_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_wait = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        id_rs1 = 5; id_use_rs1 = 1; ex_rd = 5; ex_reg_write = 1; branch_taken = 1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (observed() !== 11'b00111000000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", observed(), 11'b00111000000);
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
        #1 rst = 1'b0;
        m_wait = 0; m_err = 0; m_stall = 0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (observed() !== 11'b11010100000) begin
            errors++;
            $display("FAIL reset_release_normal got=%b exp=%b", observed(), 11'b11010100000);
        end
        $display("test_reset done");
        advance();
    endtask

    task automatic test_load_use();
        // lw x5 in EX, add reads x5 in ID
        idle_inputs();
        ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
        id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b0 || idex_bubble !== 1'b1 || observed() !== model_out()) begin
            errors++;
            $display("FAIL load_use_stall got=%b exp=%b", observed(), model_out());
        end
        $display("load_use cycle1 pc_write=%b idex_bubble=%b", pc_write, idex_bubble);
        advance();
        // load moved to MEM, bubble in EX
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 5; mem_reg_write = 1;
        @(negedge clk);
        checks++;
`ifdef FWD_UNIT_EN
        if (fwd_a !== 2'b01 || pc_write !== 1'b1 || observed() !== model_out()) begin
`else
        if (pc_write !== 1'b0 || observed() !== model_out()) begin
`endif
            errors++;
            $display("FAIL load_use_next got=%b exp=%b", observed(), model_out());
        end
        $display("load_use cycle2 pc_write=%b fwd_a=%b", pc_write, fwd_a);
        advance();
    endtask

    task automatic test_branch_over_stall();
        int s0;
        idle_inputs();
        ex_rd = 9; ex_reg_write = 1; ex_mem_read = 1;
        id_rs2 = 9; id_use_rs2 = 1; branch_taken = 1;
        @(negedge clk);
        s0 = stall_cnt;
        checks++;
        if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1 || pc_write !== 1'b1 ||
            observed() !== model_out()) begin
            errors++;
            $display("FAIL branch_flush got=%b exp=%b", observed(), model_out());
        end
        advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== PERF_W'(s0)) begin
            errors++;
            $display("FAIL branch_stall_cnt got=%0d exp=%0d", stall_cnt, s0);
        end
        $display("branch_over_stall flush=%b stall_cnt=%0d", ifid_flush, stall_cnt);
        advance();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        idle_inputs();
        dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== 11'b00000000000 || observed() !== model_out()) begin
                errors++;
                $display("FAIL mem_wait_freeze%0d got=%b exp=%b", i, observed(), model_out());
            end
            advance();
        end
        // branch arrived during the freeze; it must apply on the release
        dmem_ack = 1; branch_taken = 1;
        @(negedge clk);
        checks++;
        if (observed() !== 11'b11111100000 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mem_wait_release got=%b/%0d exp=%b/3", observed(), stall_cnt, 11'b11111100000);
        end
        $display("mem_wait released stall_cnt=%0d", stall_cnt);
        advance();
    endtask

    task automatic test_timeout();
        int cyc;
        apply_reset();
        idle_inputs();
        dmem_req = 1;
        cyc = 0;
        while (!m_err && cyc < 40) begin
            advance();
            cyc++;
        end
        dmem_req = 0;
        @(negedge clk);
        checks++;
        if (cyc != MEM_TMO || mem_tmo_err !== 1'b1 || observed() !== 11'b00000000001) begin
            errors++;
            $display("FAIL timeout_err got=%b cycles=%0d exp=%b cycles=%0d", observed(), cyc, 11'b00000000001, MEM_TMO);
        end
        advance();
        dmem_ack = 1;   // late ack must not leave ERR
        @(negedge clk);
        checks++;
        if (mem_tmo_err !== 1'b1 || pc_write !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky got_err=%b pc=%b exp_err=1 pc=0", mem_tmo_err, pc_write);
        end
        advance();
        apply_reset();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (mem_tmo_err !== 1'b0 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rst_clear got_err=%b pc=%b exp_err=0 pc=1", mem_tmo_err, pc_write);
        end
        $display("timeout after %0d cycles, cleared by rst", cyc);
        advance();
    endtask

    task automatic test_x0();
        idle_inputs();
        ex_rd = 0; ex_reg_write = 1; ex_mem_read = 1;
        mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
        id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
        @(negedge clk);
        checks++;
        if (observed() !== 11'b11010100000) begin
            errors++;
            $display("FAIL x0_no_hazard got=%b exp=%b", observed(), 11'b11010100000);
        end
        $display("x0 pc_write=%b fwd_a=%b fwd_b=%b", pc_write, fwd_a, fwd_b);
        advance();
    endtask

    task automatic test_mem_writer();
        // add x3 in MEM, ID reads x3 in rs2
        idle_inputs();
        mem_rd = 3; mem_reg_write = 1; id_rs2 = 3; id_use_rs2 = 1;
        @(negedge clk);
        checks++;
`ifdef FWD_UNIT_EN
        if (pc_write !== 1'b1 || fwd_b !== 2'b01) begin
`else
        if (pc_write !== 1'b0 || idex_bubble !== 1'b1 || exmem_write !== 1'b1) begin
`endif
            errors++;
            $display("FAIL mem_writer_c1 got=%b exp=%b", observed(), model_out());
        end
        advance();
        mem_rd = 0; mem_reg_write = 0; wb_rd = 3; wb_reg_write = 1;
        @(negedge clk);
        checks++;
`ifdef FWD_UNIT_EN
        if (pc_write !== 1'b1 || fwd_b !== 2'b10) begin
`else
        if (pc_write !== 1'b1 || fwd_b !== 2'b00) begin
`endif
            errors++;
            $display("FAIL mem_writer_c2 got=%b exp=%b", observed(), model_out());
        end
        $display("mem_writer wb cycle pc_write=%b fwd_b=%b", pc_write, fwd_b);
        advance();
    endtask

    task automatic test_random();
        int bad = 0;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            id_rs1 = RA_W'($urandom_range(0, 3)); id_rs2 = RA_W'($urandom_range(0, 3));
            ex_rd  = RA_W'($urandom_range(0, 3)); mem_rd = RA_W'($urandom_range(0, 3));
            wb_rd  = RA_W'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
            mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
            branch_taken = ($urandom_range(0, 7) == 0);
            dmem_req = ($urandom_range(0, 5) == 0);
            dmem_ack = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks++;
            if (observed() !== model_out() || stall_cnt !== PERF_W'(m_stall)) begin
                errors++;
                bad++;
                $display("FAIL random_%0d got=%b/%0d exp=%b/%0d", n, observed(), stall_cnt, model_out(), m_stall);
            end
            advance();
            if (m_err) apply_reset();
        end
        $display("test_random 400 cycles, %0d bad", bad);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch_over_stall();
        test_mem_wait();
        test_timeout();
        test_x0();
        test_mem_writer();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
